// File: rtl/led_bank_blinker_if.sv
// rtl/led_bank_blinker_if.sv - config bus and LED/status bundle for led_bank_blinker
interface led_bank_blinker_if #(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 16
);
  localparam int CH_AW = $clog2(CHANNELS);

  logic                cfg_we;
  logic [CH_AW-1:0]    cfg_addr;
  logic [CNT_W-1:0]    cfg_period;
  logic                cfg_en;
  logic                cfg_mode;
  logic [CHANNELS-1:0] led;
  logic                busy;

  modport master (
    output cfg_we, cfg_addr, cfg_period, cfg_en, cfg_mode,
    input  led, busy
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_period, cfg_en, cfg_mode,
    output led, busy
  );
endinterface

// File: rtl/led_bank_blinker.sv
// rtl/led_bank_blinker.sv - multi-channel LED blinker with round-robin counters in a 1R1W RAM
module led_bank_blinker #(
  parameter int CHANNELS       = 8,
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PERIOD = 120,
  localparam int CH_AW         = $clog2(CHANNELS)
) (
  input logic               clk,
  input logic               rst_n,
  led_bank_blinker_if.slave bus
);

  localparam logic [0:0]       ST_INIT = 1'b0;
  localparam logic [0:0]       ST_RUN  = 1'b1;
  localparam logic [CH_AW-1:0] LAST_CH = CH_AW'(CHANNELS - 1);

  logic [0:0]          state;
  logic [CH_AW-1:0]    idx;        // init address in INIT, read (scan) index in RUN
  logic                pv;         // rd_data holds a valid counter for channel pch
  logic [CH_AW-1:0]    pch;
  logic                busy_q;
  logic [CHANNELS-1:0] led_q;

  logic [CNT_W-1:0]    ram [CHANNELS];
  logic [CNT_W-1:0]    rd_data;

  logic [CNT_W-1:0]    period_q [CHANNELS];
  logic [CHANNELS-1:0] en_q;
  logic [CHANNELS-1:0] mode_q;

  logic                ram_we;
  logic [CH_AW-1:0]    ram_waddr;
  logic [CNT_W-1:0]    ram_wdata;
  logic                led_next;

  // Write-port mux: zero-fill during INIT, counter update for the visited channel in RUN
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = idx;
    ram_wdata = '0;
    led_next  = led_q[pch];
    if (state == ST_INIT) begin
      ram_we = 1'b1;
    end else if (pv) begin
      ram_we    = 1'b1;
      ram_waddr = pch;
      if (!en_q[pch]) begin
        led_next = 1'b0;
      end else if (rd_data >= period_q[pch]) begin
        // '>=' so that lowering the period below the running count wraps at once
        led_next = mode_q[pch] ? 1'b1 : ~led_q[pch];
      end else begin
        ram_wdata = rd_data + CNT_W'(1);
        if (mode_q[pch]) led_next = 1'b0;
      end
    end
  end

  // Counter RAM: one write and one registered read per cycle, contents not reset
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    rd_data <= ram[idx];
  end

  // Sequencer: INIT sweep, then round-robin scan with a one-cycle read/compute pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      idx    <= '0;
      pv     <= 1'b0;
      pch    <= '0;
      busy_q <= 1'b1;
      led_q  <= '0;
    end else begin
      idx <= (idx == LAST_CH) ? '0 : idx + 1'b1;
      if (state == ST_INIT) begin
        if (idx == LAST_CH) begin
          state  <= ST_RUN;
          busy_q <= 1'b0;
        end
      end else begin
        pv  <= 1'b1;
        pch <= idx;
        if (pv) led_q[pch] <= led_next;
      end
    end
  end

  // Config registers: writes accepted in any state, old values used by a same-cycle compute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        period_q[i] <= CNT_W'(DEFAULT_PERIOD);
      end
      en_q   <= '1;
      mode_q <= '0;
    end else if (bus.cfg_we && (int'(bus.cfg_addr) < CHANNELS)) begin
      period_q[bus.cfg_addr] <= bus.cfg_period;
      en_q[bus.cfg_addr]     <= bus.cfg_en;
      mode_q[bus.cfg_addr]   <= bus.cfg_mode;
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_led_bank_blinker.sv
// tb/tb_led_bank_blinker.sv - self-checking bench for led_bank_blinker
module tb_led_bank_blinker;

  localparam int CH   = 4;
  localparam int CW   = 16;
  localparam int DEFP = 120;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cur;
  bit   chk_en = 1'b0;

  led_bank_blinker_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  led_bank_blinker #(.CHANNELS(CH), .CNT_W(CW), .DEFAULT_PERIOD(DEFP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: cycle c after reset release; channel ch is evaluated in cycle CH+1+ch+k*CH
  int m_cnt [CH];
  int m_p   [CH];
  bit m_en  [CH];
  bit m_mode[CH];
  bit m_led [CH];
  int c;
  int vch;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c = 0;
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_p[i] = DEFP; m_en[i] = 1; m_mode[i] = 0; m_led[i] = 0;
      end
    end else begin
      if (c >= CH + 1) begin
        vch = (c - CH - 1) % CH;
        if (!m_en[vch]) begin
          m_cnt[vch] = 0; m_led[vch] = 0;
        end else if (m_cnt[vch] >= m_p[vch]) begin
          m_cnt[vch] = 0;
          m_led[vch] = m_mode[vch] ? 1'b1 : ~m_led[vch];
        end else begin
          m_cnt[vch] = m_cnt[vch] + 1;
          if (m_mode[vch]) m_led[vch] = 0;
        end
      end
      if (bus.cfg_we) begin
        m_p[bus.cfg_addr]    = int'(bus.cfg_period);
        m_en[bus.cfg_addr]   = bus.cfg_en;
        m_mode[bus.cfg_addr] = bus.cfg_mode;
      end
      c = c + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [CH-1:0] exp_led;
      for (int i = 0; i < CH; i++) exp_led[i] = m_led[i];
      check("model_busy", int'(bus.busy), (c < CH) ? 1 : 0);
      check("model_led", int'(bus.led), int'(exp_led));
    end
  end

  task automatic wait_cyc(input int n);
    while (cur < n) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic cfg_write(input int a, input int p, input bit en, input bit mode);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 2'(a);
    bus.cfg_period = 16'(p);
    bus.cfg_en     = en;
    bus.cfg_mode   = mode;
    @(negedge clk);
    cur++;
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_period = '0;
    bus.cfg_en = 1'b0; bus.cfg_mode = 1'b0;
    cur = 0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #1 rst_n = 1'b1;
    cur = 0;
    #1;
    check("busy_c0", int'(bus.busy), 1);
    check("led_c0", int'(bus.led), 0);
    cfg_write(0, 3, 1, 0);
    check("busy_c1", int'(bus.busy), 1);
    cfg_write(2, 2, 1, 1);
    check("busy_c2", int'(bus.busy), 1);
    cfg_write(3, 3, 1, 0);
    check("busy_c3", int'(bus.busy), 1);
    wait_cyc(4);  check("busy_c4", int'(bus.busy), 0);
    check("led_c4", int'(bus.led), 0);
    wait_cyc(15); check("pulse2_c15", int'(bus.led[2]), 0);
    wait_cyc(16); check("pulse2_c16", int'(bus.led[2]), 1);
    wait_cyc(17); check("tog0_c17", int'(bus.led[0]), 0);
    wait_cyc(18); check("tog0_c18", int'(bus.led[0]), 1);
    wait_cyc(19); check("pulse2_c19", int'(bus.led[2]), 1);
    wait_cyc(20); check("pulse2_c20", int'(bus.led[2]), 0);
    wait_cyc(27); check("pulse2_c27", int'(bus.led[2]), 0);
    wait_cyc(28); check("pulse2_c28", int'(bus.led[2]), 1);
    wait_cyc(33); check("tog0_c33", int'(bus.led[0]), 1);
    wait_cyc(34); check("tog0_c34", int'(bus.led[0]), 0);
    wait_cyc(43); cfg_write(1, 5, 1, 0);
    wait_cyc(46); check("lowp1_c46", int'(bus.led[1]), 0);
    wait_cyc(47); check("lowp1_c47", int'(bus.led[1]), 1);
    wait_cyc(54); cfg_write(3, 3, 0, 0);
    wait_cyc(56); check("dis3_c56", int'(bus.led[3]), 1);
    wait_cyc(57); check("dis3_c57", int'(bus.led[3]), 0);
    wait_cyc(68); cfg_write(3, 3, 1, 0);
    wait_cyc(71); check("lowp1_c71", int'(bus.led[1]), 0);
    wait_cyc(84); check("en3_c84", int'(bus.led[3]), 0);
    wait_cyc(85); check("en3_c85", int'(bus.led[3]), 1);
    wait_cyc(90); check("leds_c90", int'(bus.led), 4'b1101);
    #2 rst_n = 1'b0;
    #1;
    check("rst_led", int'(bus.led), 0);
    check("rst_busy", int'(bus.busy), 1);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cur = 0;
    wait_cyc(3);   check("rbusy_c3", int'(bus.busy), 1);
    wait_cyc(4);   check("rbusy_c4", int'(bus.busy), 0);
    wait_cyc(485); check("def_c485", int'(bus.led), 4'b0000);
    wait_cyc(486); check("def_c486", int'(bus.led), 4'b0001);
    wait_cyc(487); check("def_c487", int'(bus.led), 4'b0011);
    wait_cyc(489); check("def_c489", int'(bus.led), 4'b1111);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
